uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single transmit path of the UART wrapper between two byte-stream clients (A and B) with round-robin arbitration and message locking. A granted client keeps the UART until it sends a byte marked `last`, or until it stalls longer than a timeout. The block sits between the clients and the wrapper's `tx_data`/`tx_wr`/`tx_flag` ports and runs in the same clock domain.

## Interface
- `LOCK_TIMEOUT`, 16'd0: idle SEND cycles allowed while a lock is held before forced release; 0 disables the timeout.
- `clk` in 1: system clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `a_valid` in 1: client A has a byte; must hold `a_data`/`a_last` stable until accepted.
- `a_data` in 8: client A byte.
- `a_last` in 1: byte ends A's message; releases the grant after it is sent.
- `a_ready` out 1: A byte accepted on cycles where `a_valid && a_ready`.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as for A, for client B.
- `uart_tx_data` out 8: byte to wrapper `tx_data`.
- `uart_tx_wr` out 1: one-cycle write strobe to wrapper `tx_wr`.
- `uart_tx_flag` in 1: wrapper `tx_flag`; 1 = idle/ready, 0 = byte in flight.
- `grant` out 2: one-hot owner, bit0 = A, bit1 = B; 2'b00 = none.
- `timeout` out 1: one-cycle pulse on forced release.

## Operation
- States: ARB, SEND, BUSY, DRAIN.
- ARB:
  - If no valid, stay.
  - If exactly one client is valid, grant it.
  - If both are valid, grant the client not granted last (`last_grant` register, reset = B, so A wins first).
  - Move to SEND.
- SEND:
  - `x_ready = (state==SEND) && grant[x] && uart_tx_flag`, combinational. The ungranted ready is always 0.
  - On accept: `uart_tx_data <= x_data`, `uart_tx_wr <= 1`, latch `x_last` into `last_r`, clear the timeout counter, go to BUSY.
  - Timeout counter: if `LOCK_TIMEOUT != 0` and the granted client is not valid, increment a 16-bit counter. When it reaches `LOCK_TIMEOUT-1`, pulse `timeout`, clear `grant`, set `last_grant` to the released client, and go to ARB.
- BUSY: `uart_tx_wr` is high only in the first BUSY cycle. Wait for `uart_tx_flag == 0`, then go to DRAIN.
- DRAIN: wait for `uart_tx_flag == 1`.
  - If `last_r` is set: clear `grant`, update `last_grant`, go to ARB.
  - Otherwise: return to SEND with the grant held.
- The ungranted client's valid is ignored while locked. Dropping valid before acceptance is legal and nothing is sent.
- `uart_tx_wr` never asserts while `uart_tx_flag == 0` or outside the first BUSY cycle.
- Timeout counter: 16 bits, no wrap (it releases before the wrap point). Cleared on every accept and on every entry to SEND from ARB.

## Timing
- Reset values: state ARB, `grant` 2'b00, `uart_tx_wr` 0, `uart_tx_data` 8'h00, `timeout` 0, `last_grant` = B, counter 0, both readys 0.
- Reset mid-operation: the next cycle is ARB with all outputs at reset values. Any pending `uart_tx_wr` is dropped. The wrapper shares `reset` and clears its own in-flight byte.
- Cycle numbering: valid rises in cycle 0 (state ARB).
  - Cycle 1: grant set, SEND, ready high if `uart_tx_flag == 1`, so the accept happens in cycle 1.
  - Cycle 2: `uart_tx_wr = 1`, `uart_tx_data` valid.
  - Cycle 3: wrapper `tx_flag` low; transition to DRAIN at the end of cycle 3.
- Back-to-back bytes in a lock: the next ready is 1 cycle after `uart_tx_flag` returns high.
- Release to a new grant: ARB adds 1 cycle.
- Timeout fires on the `LOCK_TIMEOUT`-th consecutive SEND cycle with the granted client not valid.

## Test plan
- Single byte: after reset, A valid with 0x41 and last=1 at cycle 0 -> `a_ready` in cycle 1, `uart_tx_wr` pulse for exactly 1 cycle in cycle 2 with data 0x41, `grant` returns to 00 one cycle after `tx_flag` rises.
- Simultaneous request: A and B valid in the same cycle after reset, each with a last byte -> A sent first, then B. Repeat -> A again (alternation).
- Message lock: A sends 0x48, 0x69, 0x0A (last on 0x0A) while B holds 0x42 valid -> UART sequence is 0x48, 0x69, 0x0A, 0x42, and `b_ready` stays 0 until A is released.
- Timeout: `LOCK_TIMEOUT=8`, A sends 0x31 with last=0, then drops valid, B valid -> `timeout` pulses after 8 idle SEND cycles, B is granted on the next cycle. With `LOCK_TIMEOUT=0` the lock is held indefinitely.
- Reset mid-transfer: assert `reset` in the `uart_tx_wr` cycle -> next cycle `uart_tx_wr=0`, `grant=00`, state ARB, and A wins the next arbitration.
- Protocol check, over 1000 random A/B traffic bytes against a wrapper model (`tx_flag` drops the cycle after `tx_wr`) -> zero `uart_tx_wr` pulses while `tx_flag==0`, every accepted byte transmitted exactly once and in order per client.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Bundles the two client byte streams (A and B), the UART wrapper
//            transmit port and the arbiter status outputs into one interface.
// Modports : master - environment side: drives client valid/data/last and the
//                     wrapper tx_flag, observes ready, tx strobe and status.
//            slave  - arbiter side: the mirror image of master.
// Signals  : a_valid/a_data/a_last/a_ready   client A byte handshake
//            b_valid/b_data/b_last/b_ready   client B byte handshake
//            uart_tx_data/uart_tx_wr         byte and write strobe to wrapper
//            uart_tx_flag                    wrapper idle (1) / busy (0)
//            grant                           one-hot owner, bit0=A, bit1=B
//            timeout                         one-cycle forced-release pulse
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_last;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_last;
  logic       b_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_wr;
  logic       uart_tx_flag;
  logic [1:0] grant;
  logic       timeout;

  modport master (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  uart_tx_data, uart_tx_wr,
    output uart_tx_flag,
    input  grant, timeout
  );

  modport slave (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output uart_tx_data, uart_tx_wr,
    input  uart_tx_flag,
    output grant, timeout
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares the single UART transmit path between two byte-stream
//            clients with round-robin arbitration and message locking. The
//            granted client keeps the UART until it sends a byte marked last,
//            or until it stalls for LOCK_TIMEOUT consecutive SEND cycles.
// Params   : LOCK_TIMEOUT - idle SEND cycles tolerated before forced release
//                           (0 disables the timeout).
// Ports    : clk   - system clock, rising edge
//            reset - synchronous, active-high
//            bus   - uart_tx_arbiter_if.slave (client handshakes, wrapper
//                    tx_data/tx_wr/tx_flag, grant and timeout status)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter logic [15:0] LOCK_TIMEOUT = 16'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_arbiter_if.slave       bus
);

  localparam logic [1:0] c_ST_ARB   = 2'd0;
  localparam logic [1:0] c_ST_SEND  = 2'd1;
  localparam logic [1:0] c_ST_BUSY  = 2'd2;
  localparam logic [1:0] c_ST_DRAIN = 2'd3;

  // Encoding of the last_grant register: 0 = A was served last, 1 = B.
  localparam logic c_LAST_B = 1'b1;

  // Counter value on the LOCK_TIMEOUT-th idle cycle (only meaningful when
  // the timeout is enabled, so the wrap for LOCK_TIMEOUT=0 is harmless).
  localparam logic [15:0] c_TIMEOUT_LAST = LOCK_TIMEOUT - 16'd1;
  localparam logic        c_TIMEOUT_EN   = (LOCK_TIMEOUT != 16'd0);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [1:0]  r_grant;
  logic        r_last_grant;
  logic [7:0]  r_tx_data;
  logic        r_tx_wr;
  logic        r_last;
  logic        r_timeout;
  logic [15:0] r_idle_cnt;

  logic        w_sel_valid;
  logic [7:0]  w_sel_data;
  logic        w_sel_last;
  logic        w_any_req;
  logic        w_pick_a;
  logic        w_accept;
  logic        w_idle_send;
  logic        w_timeout_hit;
  logic        w_a_ready;
  logic        w_b_ready;

  // Granted client's stream; with no grant the selected valid is 0.
  assign w_sel_valid = (r_grant[0] & bus.a_valid) | (r_grant[1] & bus.b_valid);
  assign w_sel_data  = r_grant[1] ? bus.b_data : bus.a_data;
  assign w_sel_last  = r_grant[1] ? bus.b_last : bus.a_last;

  // Round robin: on a tie the client not served last wins.
  assign w_any_req = bus.a_valid | bus.b_valid;
  assign w_pick_a  = bus.a_valid & (~bus.b_valid | (r_last_grant == c_LAST_B));

  assign w_accept      = (r_state == c_ST_SEND) & w_sel_valid & bus.uart_tx_flag;
  assign w_idle_send   = (r_state == c_ST_SEND) & ~w_sel_valid;
  assign w_timeout_hit = c_TIMEOUT_EN & w_idle_send & (r_idle_cnt == c_TIMEOUT_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_ARB: begin
        if (w_any_req) w_state_nxt = c_ST_SEND;
      end
      c_ST_SEND: begin
        if (w_accept)           w_state_nxt = c_ST_BUSY;
        else if (w_timeout_hit) w_state_nxt = c_ST_ARB;
      end
      c_ST_BUSY: begin
        // The wrapper drops tx_flag once it has taken the byte.
        if (!bus.uart_tx_flag) w_state_nxt = c_ST_DRAIN;
      end
      c_ST_DRAIN: begin
        if (bus.uart_tx_flag) w_state_nxt = r_last ? c_ST_ARB : c_ST_SEND;
      end
      default: w_state_nxt = c_ST_ARB;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: readys are combinational so a byte is accepted in the
  // first SEND cycle in which the wrapper is idle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (r_state == c_ST_SEND && bus.uart_tx_flag) begin
      w_a_ready = r_grant[0];
      w_b_ready = r_grant[1];
    end
  end

  assign bus.a_ready      = w_a_ready;
  assign bus.b_ready      = w_b_ready;
  assign bus.uart_tx_data = r_tx_data;
  assign bus.uart_tx_wr   = r_tx_wr;
  assign bus.grant        = r_grant;
  assign bus.timeout      = r_timeout;

  // --------------------------------------------------------------------------
  // Grant, transmit register and lock timeout datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= 2'b00;
      r_last_grant <= c_LAST_B;
      r_tx_data    <= 8'h00;
      r_tx_wr      <= 1'b0;
      r_last       <= 1'b0;
      r_timeout    <= 1'b0;
      r_idle_cnt   <= 16'd0;
    end else begin
      // Strobes are single-cycle by default.
      r_tx_wr   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        c_ST_ARB: begin
          if (w_any_req) begin
            r_grant    <= w_pick_a ? 2'b01 : 2'b10;
            r_idle_cnt <= 16'd0;
          end
        end
        c_ST_SEND: begin
          if (w_accept) begin
            r_tx_data  <= w_sel_data;
            r_tx_wr    <= 1'b1;
            r_last     <= w_sel_last;
            r_idle_cnt <= 16'd0;
          end else if (w_timeout_hit) begin
            r_timeout    <= 1'b1;
            r_grant      <= 2'b00;
            r_last_grant <= r_grant[1];
            r_idle_cnt   <= 16'd0;
          end else if (c_TIMEOUT_EN && w_idle_send) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
          end else begin
            // Client is presenting a byte but the wrapper is busy: the
            // stall is not an idle cycle, so the idle run restarts.
            r_idle_cnt <= 16'd0;
          end
        end
        c_ST_DRAIN: begin
          if (bus.uart_tx_flag && r_last) begin
            r_grant      <= 2'b00;
            r_last_grant <= r_grant[1];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. Two instances share
//            the same client stimulus: dut0 (no lock timeout) and dut8
//            (LOCK_TIMEOUT=8). Each has its own UART wrapper model that drops
//            tx_flag the cycle after tx_wr and logs every transmitted byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_valid, a_last, b_valid, b_last;
  logic [7:0] a_data, b_data;
  logic       flag0, flag8;
  int         cnt0, cnt8;
  bit         rand_mode = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] uart0[$];
  logic [7:0] uart8[$];
  logic [8:0] acc_a[$];
  logic [8:0] acc_b[$];

  int wr_cnt0 = 0, to_cnt0 = 0, to_cnt8 = 0;
  int viol_wr_busy = 0, viol_wr_wide = 0, viol_ready = 0;
  logic prev_wr0 = 1'b0;

  uart_tx_arbiter_if bus0();
  uart_tx_arbiter_if bus8();

  uart_tx_arbiter #(.LOCK_TIMEOUT(16'd0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  uart_tx_arbiter #(.LOCK_TIMEOUT(16'd8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

  assign bus0.a_valid = a_valid;  assign bus8.a_valid = a_valid;
  assign bus0.a_data  = a_data;   assign bus8.a_data  = a_data;
  assign bus0.a_last  = a_last;   assign bus8.a_last  = a_last;
  assign bus0.b_valid = b_valid;  assign bus8.b_valid = b_valid;
  assign bus0.b_data  = b_data;   assign bus8.b_data  = b_data;
  assign bus0.b_last  = b_last;   assign bus8.b_last  = b_last;
  assign bus0.uart_tx_flag = flag0;
  assign bus8.uart_tx_flag = flag8;

  // Wrapper models: busy for 2 cycles normally, 1..4 cycles in random mode.
  always @(posedge clk) begin
    if (reset) begin
      flag0 <= 1'b1; cnt0 <= 0;
    end else if (bus0.uart_tx_wr) begin
      flag0 <= 1'b0;
      cnt0  <= rand_mode ? int'($urandom_range(0, 3)) : 1;
      uart0.push_back(bus0.uart_tx_data);
    end else if (!flag0) begin
      if (cnt0 == 0) flag0 <= 1'b1; else cnt0 <= cnt0 - 1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      flag8 <= 1'b1; cnt8 <= 0;
    end else if (bus8.uart_tx_wr) begin
      flag8 <= 1'b0;
      cnt8  <= 1;
      uart8.push_back(bus8.uart_tx_data);
    end else if (!flag8) begin
      if (cnt8 == 0) flag8 <= 1'b1; else cnt8 <= cnt8 - 1;
    end
  end

  // Protocol monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.uart_tx_wr) wr_cnt0 <= wr_cnt0 + 1;
      if (bus0.uart_tx_wr && !flag0) viol_wr_busy <= viol_wr_busy + 1;
      if (bus0.uart_tx_wr && prev_wr0) viol_wr_wide <= viol_wr_wide + 1;
      if ((bus0.a_ready && !bus0.grant[0]) || (bus0.b_ready && !bus0.grant[1]))
        viol_ready <= viol_ready + 1;
      if (bus0.timeout) to_cnt0 <= to_cnt0 + 1;
      if (bus8.timeout) to_cnt8 <= to_cnt8 + 1;
    end
    prev_wr0 <= bus0.uart_tx_wr;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // --------------------------------------------------------------------------
  task automatic do_reset();
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_a(input logic [7:0] d, input logic l, input bit use8);
    int t = 0;
    a_valid = 1'b1; a_data = d; a_last = l;
    while (!(use8 ? bus8.a_ready : bus0.a_ready) && t < 300) begin
      @(negedge clk); t++;
    end
    n_vec++;
    if (t >= 300) begin
      n_err++; $display("FAIL a_accept_wait: waited %0d cycles, required < 300", t);
    end else acc_a.push_back({l, d});
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] d, input logic l, input bit use8);
    int t = 0;
    b_valid = 1'b1; b_data = d; b_last = l;
    while (!(use8 ? bus8.b_ready : bus0.b_ready) && t < 300) begin
      @(negedge clk); t++;
    end
    n_vec++;
    if (t >= 300) begin
      n_err++; $display("FAIL b_accept_wait: waited %0d cycles, required < 300", t);
    end else acc_b.push_back({l, d});
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit use8);
    int t = 0;
    while (!(use8 ? (bus8.grant == 2'b00 && flag8) : (bus0.grant == 2'b00 && flag0)) && t < 300) begin
      @(negedge clk); t++;
    end
    n_vec++;
    if (t >= 300) begin
      n_err++; $display("FAIL idle_wait: waited %0d cycles, required < 300", t);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hFF; b_data = 8'hFF;
    a_last = 1'b1; b_last = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus0.grant !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b, want 00", bus0.grant); end
    n_vec++; if (bus0.uart_tx_wr !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b, want 0", bus0.uart_tx_wr); end
    n_vec++; if (bus0.uart_tx_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h, want 00", bus0.uart_tx_data); end
    n_vec++; if (bus0.timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b, want 0", bus0.timeout); end
    n_vec++; if ({bus0.a_ready, bus0.b_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b, want 00", {bus0.a_ready, bus0.b_ready}); end
    n_vec++; if (bus8.grant !== 2'b00) begin n_err++; $display("FAIL rst_grant8: got %b, want 00", bus8.grant); end
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus0.grant !== 2'b00) begin n_err++; $display("FAIL arb_idle_grant: got %b, want 00", bus0.grant); end
  endtask

  task automatic test_single_byte();
    int base, wrb, t;
    do_reset();
    @(negedge clk);
    base = uart0.size(); wrb = wr_cnt0;
    a_valid = 1'b1; a_data = 8'h41; a_last = 1'b1;            // cycle 0
    @(negedge clk);                                           // cycle 1
    n_vec++; if (bus0.grant !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b, want 01", bus0.grant); end
    n_vec++; if ({bus0.a_ready, bus0.b_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b, want 10", {bus0.a_ready, bus0.b_ready}); end
    @(negedge clk);                                           // cycle 2
    a_valid = 1'b0;
    n_vec++; if (bus0.uart_tx_wr !== 1'b1 || bus0.uart_tx_data !== 8'h41) begin
      n_err++; $display("FAIL single_wr: got wr=%b data=%h, want wr=1 data=41", bus0.uart_tx_wr, bus0.uart_tx_data); end
    @(negedge clk);                                           // cycle 3
    n_vec++; if (bus0.uart_tx_wr !== 1'b0) begin n_err++; $display("FAIL single_wr_width: got %b, want 0", bus0.uart_tx_wr); end
    t = 0;
    while (!flag0 && t < 50) begin @(negedge clk); t++; end
    n_vec++; if (bus0.grant !== 2'b01) begin n_err++; $display("FAIL single_grant_hold: got %b, want 01", bus0.grant); end
    @(negedge clk);
    n_vec++; if (bus0.grant !== 2'b00) begin n_err++; $display("FAIL single_release: got %b, want 00", bus0.grant); end
    n_vec++; if (wr_cnt0 - wrb !== 1) begin n_err++; $display("FAIL single_wr_count: got %0d, want 1", wr_cnt0 - wrb); end
    n_vec++; if (uart0.size() - base !== 1 || uart0[base] !== 8'h41) begin
      n_err++; $display("FAIL single_stream: got %0d bytes, want 1 byte 41", uart0.size() - base); end
  endtask

  task automatic test_simultaneous();
    int base;
    do_reset();
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      base = uart0.size();
      fork
        drive_a(8'h11 + 8'(r), 1'b1, 1'b0);
        drive_b(8'h22 + 8'(r), 1'b1, 1'b0);
      join
      wait_idle(1'b0);
      n_vec++;
      if (uart0.size() - base !== 2 || uart0[base] !== 8'h11 + 8'(r) || uart0[base+1] !== 8'h22 + 8'(r)) begin
        n_err++; $display("FAIL simul_order[%0d]: got %0d bytes first=%h, want A byte %h then B byte %h",
                          r, uart0.size() - base, uart0[base], 8'h11 + 8'(r), 8'h22 + 8'(r));
      end
    end
  endtask

  task automatic test_message_lock();
    int base, early, t;
    bit a_done;
    logic [7:0] exp_q[4];
    exp_q[0] = 8'h48; exp_q[1] = 8'h69; exp_q[2] = 8'h0A; exp_q[3] = 8'h42;
    do_reset();
    @(negedge clk);
    base = uart0.size(); early = 0; a_done = 1'b0; t = 0;
    fork
      begin
        drive_a(8'h48, 1'b0, 1'b0);
        drive_a(8'h69, 1'b0, 1'b0);
        drive_a(8'h0A, 1'b1, 1'b0);
        a_done = 1'b1;
      end
      drive_b(8'h42, 1'b1, 1'b0);
      begin
        while (!a_done && t < 400) begin
          if (bus0.b_ready) early++;
          @(negedge clk); t++;
        end
      end
    join
    wait_idle(1'b0);
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL lock_b_ready: b_ready high %0d cycles during A lock, want 0", early); end
    n_vec++; if (uart0.size() - base !== 4) begin n_err++; $display("FAIL lock_count: got %0d bytes, want 4", uart0.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (base + i >= uart0.size() || uart0[base+i] !== exp_q[i]) begin
        n_err++; $display("FAIL lock_byte[%0d]: got %h, want %h", i,
                          (base + i < uart0.size()) ? uart0[base+i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int base0, base8, to0b, to8b, run, t;
    bit seen;
    do_reset();
    @(negedge clk);
    base0 = uart0.size(); base8 = uart8.size(); to0b = to_cnt0; to8b = to_cnt8;
    drive_a(8'h31, 1'b0, 1'b1);
    b_valid = 1'b1; b_data = 8'h55; b_last = 1'b1;
    run = 0; seen = 1'b0; t = 0;
    while (!seen && t < 100) begin
      @(negedge clk); t++;
      if (bus8.timeout) seen = 1'b1;
      else if (bus8.a_ready) run++;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL to_pulse: no timeout within %0d cycles, want one", t); end
    n_vec++; if (run !== 8) begin n_err++; $display("FAIL to_idle_cycles: got %0d idle SEND cycles, want 8", run); end
    n_vec++; if (bus8.grant !== 2'b00) begin n_err++; $display("FAIL to_release: got %b, want 00", bus8.grant); end
    @(negedge clk);
    n_vec++; if (bus8.grant !== 2'b10) begin n_err++; $display("FAIL to_regrant: got %b, want 10", bus8.grant); end
    n_vec++; if (bus8.timeout !== 1'b0) begin n_err++; $display("FAIL to_width: got %b, want 0", bus8.timeout); end
    @(negedge clk);
    b_valid = 1'b0;
    wait_idle(1'b1);
    n_vec++; if (to_cnt8 - to8b !== 1) begin n_err++; $display("FAIL to_count: got %0d pulses, want 1", to_cnt8 - to8b); end
    n_vec++;
    if (uart8.size() - base8 !== 2 || uart8[base8] !== 8'h31 || uart8[base8+1] !== 8'h55) begin
      n_err++; $display("FAIL to_stream: got %0d bytes, want 31 then 55", uart8.size() - base8);
    end
    repeat (20) @(negedge clk);
    n_vec++; if (bus0.grant !== 2'b01) begin n_err++; $display("FAIL nolimit_hold: got %b, want 01", bus0.grant); end
    n_vec++; if (to_cnt0 !== to0b) begin n_err++; $display("FAIL nolimit_pulse: got %0d pulses, want 0", to_cnt0 - to0b); end
    n_vec++; if (uart0.size() - base0 !== 1) begin n_err++; $display("FAIL nolimit_stream: got %0d bytes, want 1", uart0.size() - base0); end
  endtask

  task automatic test_reset_mid();
    int base, t;
    logic [1:0] g;
    do_reset();
    @(negedge clk);
    base = uart0.size();
    a_valid = 1'b1; a_data = 8'h77; a_last = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus0.uart_tx_wr !== 1'b1) begin n_err++; $display("FAIL midrst_pre_wr: got %b, want 1", bus0.uart_tx_wr); end
    reset = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus0.uart_tx_wr !== 1'b0 || bus0.grant !== 2'b00 || bus0.a_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_state: got wr=%b grant=%b a_ready=%b, want 0 00 0", bus0.uart_tx_wr, bus0.grant, bus0.a_ready); end
    reset = 1'b0;
    @(negedge clk);
    g = 2'b00; t = 0;
    fork
      drive_a(8'h5A, 1'b1, 1'b0);
      drive_b(8'hA5, 1'b1, 1'b0);
      begin
        while (bus0.grant == 2'b00 && t < 20) begin @(negedge clk); t++; end
        g = bus0.grant;
      end
    join
    wait_idle(1'b0);
    n_vec++; if (g !== 2'b01) begin n_err++; $display("FAIL midrst_first: got %b, want 01", g); end
    n_vec++;
    if (uart0.size() - base !== 2 || uart0[base] !== 8'h5A || uart0[base+1] !== 8'hA5) begin
      n_err++; $display("FAIL midrst_stream: got %0d bytes, want 5A then A5", uart0.size() - base);
    end
  endtask

  task automatic client_a(input int n);
    int rem = 0;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (rem == 0) rem = int'($urandom_range(1, 4));
      if (i == n - 1) rem = 1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = 8'($urandom); d[7] = 1'b0;
      drive_a(d, rem == 1, 1'b0);
      rem--;
    end
  endtask

  task automatic client_b(input int n);
    int rem = 0;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (rem == 0) rem = int'($urandom_range(1, 4));
      if (i == n - 1) rem = 1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = 8'($urandom); d[7] = 1'b1;
      drive_b(d, rem == 1, 1'b0);
      rem--;
    end
  endtask

  // Reference: the UART stream must be an interleaving of whole messages,
  // each client's bytes appearing exactly once and in acceptance order.
  task automatic test_random_traffic();
    int base, ia, ib, vb, ww, vr;
    bit open, open_b;
    logic [7:0] d;
    logic [8:0] e;
    do_reset();
    @(negedge clk);
    acc_a.delete(); acc_b.delete();
    rand_mode = 1'b1;
    base = uart0.size(); vb = viol_wr_busy; ww = viol_wr_wide; vr = viol_ready;
    fork
      client_a(500);
      client_b(500);
    join
    wait_idle(1'b0);
    rand_mode = 1'b0;
    n_vec++; if (uart0.size() - base !== 1000) begin n_err++; $display("FAIL rnd_count: got %0d bytes, want 1000", uart0.size() - base); end
    n_vec++; if (viol_wr_busy !== vb) begin n_err++; $display("FAIL rnd_wr_busy: got %0d strobes while busy, want 0", viol_wr_busy - vb); end
    n_vec++; if (viol_wr_wide !== ww) begin n_err++; $display("FAIL rnd_wr_width: got %0d multi-cycle strobes, want 0", viol_wr_wide - ww); end
    n_vec++; if (viol_ready !== vr) begin n_err++; $display("FAIL rnd_ready: got %0d ungranted readys, want 0", viol_ready - vr); end
    ia = 0; ib = 0; open = 1'b0; open_b = 1'b0;
    for (int i = base; i < uart0.size(); i++) begin
      d = uart0[i];
      if (d[7]) e = (ib < acc_b.size()) ? acc_b[ib] : {1'b1, ~d};
      else      e = (ia < acc_a.size()) ? acc_a[ia] : {1'b1, ~d};
      if (d[7]) ib++; else ia++;
      n_vec++;
      if (d !== e[7:0]) begin n_err++; $display("FAIL rnd_byte[%0d]: got %h, want %h", i - base, d, e[7:0]); end
      n_vec++;
      if (open && open_b !== d[7]) begin
        n_err++; $display("FAIL rnd_lock[%0d]: got client %0d inside open message, want client %0d", i - base, d[7], open_b);
      end
      open = ~e[8]; open_b = d[7];
    end
    n_vec++; if (ia !== acc_a.size() || ib !== acc_b.size()) begin
      n_err++; $display("FAIL rnd_all_sent: got A %0d/%0d B %0d/%0d", ia, acc_a.size(), ib, acc_b.size()); end
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_simultaneous();
    test_message_lock();
    test_timeout();
    test_reset_mid();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
